// File: rtl/demux_1x8_deser.sv
// Receive side of the select-scan link: demultiplexes one serial line onto N registered
// lines and hands each completed scan to a consumer as a parallel word (valid/ack).
module demux_1x8_deser #(
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               din,
  input  logic               din_valid,
  input  logic               word_ack,
  output logic [SEL_W-1:0]   sel,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [(1<<SEL_W)-1:0] word,
  output logic               word_valid,
  output logic               overrun,
  output logic               busy
);
  localparam int N = 1 << SEL_W;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state, state_nxt;
  logic           go, accept, complete;
  logic [N-1:0]   y_nxt;

  // stop beats start; a start cycle never accepts the bit on din
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    accept    = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = COLLECT;
      go        = 1'b1;
    end else if (state == COLLECT && din_valid) begin
      accept = 1'b1;
    end
  end

  assign complete = accept && (sel == SEL_W'(N-1));
  assign busy     = (state == COLLECT);

  always_comb begin
    y_nxt = y;
    if (go)          y_nxt = '0;
    else if (accept) y_nxt[sel] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      y          <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      y <= y_nxt;
      if (stop || go)  sel <= '0;
      else if (accept) sel <= sel + SEL_W'(1);
      if (complete) word <= {din, y[N-2:0]};
      if (complete)      word_valid <= 1'b1;
      else if (word_ack) word_valid <= 1'b0;
      // overrun is only cleared by a fresh start out of IDLE
      if (go && state == IDLE)                        overrun <= 1'b0;
      else if (complete && word_valid && !word_ack)   overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_1x8_deser.sv
// Directed bench for demux_1x8_deser: reset, scans, overrun, gaps, restart and stop.
module tb_demux_1x8_deser;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, din, din_valid, word_ack;
  logic [2:0] sel;
  logic [7:0] y, word;
  logic       word_valid, overrun, busy;
  int         checks = 0;
  int         errors = 0;

  demux_1x8_deser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .din(din),
    .din_valid(din_valid), .word_ack(word_ack), .sel(sel), .y(y), .word(word),
    .word_valid(word_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic st, input logic sp, input logic d, input logic dv,
                     input logic ack);
    start = st; stop = sp; din = d; din_valid = dv; word_ack = ack;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic ack_last);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, b[i], 1'b1, (i == 7) ? ack_last : 1'b0);
    start = 0; stop = 0; din = 0; din_valid = 0; word_ack = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; stop = 0; din = 0; din_valid = 0; word_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sel, y, word, word_valid, overrun, busy} !== 22'd0) begin
      errors++; $display("FAIL reset_state: got %h want 0", {sel, y, word, word_valid, overrun, busy});
    end
    rst_n = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0);
    checks++;
    if (sel !== 3'd3 || y !== 8'h07 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_scan: sel=%0d y=%h busy=%b want 3 07 1", sel, y, busy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({sel, y, word, word_valid, overrun, busy} !== 22'd0) begin
      errors++; $display("FAIL reset_midscan: got %h want 0", {sel, y, word, word_valid, overrun, busy});
    end
    @(posedge clk); #3 rst_n = 1;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_scan;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1'(8'hB6 >> i), 1, 0);
    checks++;
    if (word_valid !== 1'b0 || sel !== 3'd7) begin
      errors++; $display("FAIL scan_before_last: wv=%b sel=%0d want 0 7", word_valid, sel);
    end
    cyc(0, 0, 1'b1, 1, 0);
    din_valid = 0;
    checks++;
    if (word !== 8'hB6 || word_valid !== 1'b1 || y !== 8'hB6 || sel !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL scan_word: word=%h wv=%b y=%h sel=%0d busy=%b want B6 1 B6 0 1",
                         word, word_valid, y, sel, busy);
    end
    cyc(0, 0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL scan_ack: wv=%b ov=%b want 0 0", word_valid, overrun);
    end
  endtask

  task automatic test_back_to_back;
    send(8'hB6, 0);
    send(8'h5A, 0);
    checks++;
    if (word !== 8'h5A || word_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun: word=%h wv=%b ov=%b want 5A 1 1", word, word_valid, overrun);
    end
    cyc(1, 0, 1, 1, 0);
    checks++;
    if (overrun !== 1'b1 || sel !== 3'd0 || y !== 8'h00 || word_valid !== 1'b1) begin
      errors++; $display("FAIL restart_keeps_overrun: ov=%b sel=%0d y=%h wv=%b want 1 0 00 1",
                         overrun, sel, y, word_valid);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (overrun !== 1'b0 || word_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL idle_start_clears: ov=%b wv=%b busy=%b want 0 0 1", overrun, word_valid, busy);
    end
    send(8'hB6, 0);
    send(8'h5A, 1);
    checks++;
    if (word !== 8'h5A || word_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_ack: word=%h wv=%b ov=%b want 5A 1 0", word, word_valid, overrun);
    end
  endtask

  task automatic test_gaps;
    int cnt;
    logic [7:0] b;
    b = 8'hB6;
    cnt = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) begin
        cyc(0, 0, b[cnt], 1, 0);
        cnt++;
      end else begin
        cyc(0, 0, ~b[cnt], 0, 0);
      end
      if (i == 6) begin
        checks++;
        if (sel !== 3'd4) begin
          errors++; $display("FAIL gap_sel_mid: sel=%0d want 4", sel);
        end
      end
      if (i == 9) begin
        checks++;
        if (sel !== 3'd5) begin
          errors++; $display("FAIL gap_sel_hold: sel=%0d want 5", sel);
        end
      end
    end
    din_valid = 0;
    checks++;
    if (word !== 8'hB6 || word_valid !== 1'b1 || sel !== 3'd0) begin
      errors++; $display("FAIL gap_word: word=%h wv=%b sel=%0d want B6 1 0", word, word_valid, sel);
    end
  endtask

  task automatic test_restart;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    checks++;
    if (sel !== 3'd0 || y !== 8'h00 || word_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear: sel=%0d y=%h wv=%b busy=%b want 0 00 0 1",
                         sel, y, word_valid, busy);
    end
    send(8'h3C, 0);
    checks++;
    if (word !== 8'h3C || y !== 8'h3C || word_valid !== 1'b1) begin
      errors++; $display("FAIL restart_word: word=%h y=%h wv=%b want 3C 3C 1", word, y, word_valid);
    end
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b1 || word !== 8'h3C) begin
      errors++; $display("FAIL stop_holds_word: busy=%b wv=%b word=%h want 0 1 3C", busy, word_valid, word);
    end
    cyc(0, 0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ack: wv=%b want 0", word_valid);
    end
  endtask

  task automatic test_stop;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    checks++;
    if (busy !== 1'b0 || sel !== 3'd0 || y !== 8'h0D || word_valid !== 1'b0) begin
      errors++; $display("FAIL stop_midscan: busy=%b sel=%0d y=%h wv=%b want 0 0 0D 0",
                         busy, sel, y, word_valid);
    end
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || y !== 8'h0D) begin
      errors++; $display("FAIL start_stop: busy=%b y=%h want 0 0D", busy, y);
    end
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
    checks++;
    if (y !== 8'h0D || sel !== 3'd0 || word_valid !== 1'b0) begin
      errors++; $display("FAIL idle_din: y=%h sel=%0d wv=%b want 0D 0 0", y, sel, word_valid);
    end
    cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    checks++;
    if (y !== 8'h01 || sel !== 3'd1) begin
      errors++; $display("FAIL start_bit_ignored: y=%h sel=%0d want 01 1", y, sel);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_back_to_back;
    test_gaps;
    test_restart;
    test_stop;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
